ps2_scan_receiver: RTL
======================

Name: ps2_scan_receiver

Overview:
- Upstream neighbour of the memory-mapped keyboard register at address 1023.
- Deserialises raw PS/2 keyboard frames into scan-code bytes, strips E0/F0 prefixes and tracks make/break.
- Presents one stable byte plus a clean, glitch-free single-cycle strobe; the memory wrapper's keyboard flip-flop latches on the strobe's rising edge.
- Sits between the FPGA PS/2 pins and the memory wrapper's ps2data/ps2data_clock inputs.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples needed before filtered ps2_clk/ps2_data change state
TIMEOUT_CYC, 50000, clk cycles allowed between falling ps2_clk edges inside a frame (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
key_code  output  8  last decoded code; 0x00 after a break (release)
key_strobe  output  1  one-clk pulse, registered; rising edge marks a new key_code
key_ext  output  1  1 if the last code was E0-prefixed
frame_err  output  1  one-clk pulse on parity, stop-bit or timeout error

Behaviour:
- Reset (rst=0, async): key_code=0x00, key_strobe=0, key_ext=0, frame_err=0. FSM goes to IDLE; break/ext flags cleared; filters preset to 1; counters cleared. Reset mid-frame discards the partial frame.
- Input path: 2-FF synchroniser on each pin, followed by a saturating filter. A filtered output flips only after FILTER_LEN consecutive clk samples of the new value.
- fall = filtered ps2_clk 1->0 this cycle. Data is sampled from filtered ps2_data on fall.
- Frame FSM, all transitions on fall unless noted:
  - IDLE: data=0 -> DATA, bit count=0. data=1 -> stay IDLE; no error.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: check odd parity over 8 data bits + parity bit; store the result. -> STOP.
  - STOP: data=1 and parity ok -> byte accepted. Otherwise frame_err pulse and byte dropped. Either case -> IDLE.
- Timeout: in any non-IDLE state a counter increments each clk and clears on fall. Reaching TIMEOUT_CYC forces IDLE and pulses frame_err, with flags unchanged.
- Accepted byte handling:
  - 0xE0: set ext flag; no output.
  - 0xF0: set break flag; no output.
  - Other byte b: key_ext<=ext flag. key_code<=(break ? 0x00 : b). Both flags cleared.
- Output timing: key_code and key_ext update in cycle N, one cycle after the STOP fall. key_strobe=1 in cycle N+1 only. key_code is held until the next accepted non-prefix byte. Guaranteed key_code setup to the strobe rising edge is at least 1 clk.
- Repeated make codes (typematic) each produce a strobe, even if the value is unchanged.
- frame_err never coincides with key_strobe for the same frame. An error does not modify key_code.
- The block never drives PS/2 pins (receive-only).
- Implementation: FSM 2 bits, bit counter 3 bits, shift register 9 bits, timeout counter of $clog2(TIMEOUT_CYC+1) bits, 2 filter counters of $clog2(FILTER_LEN+1) bits.

Test Plan:
- Reset: assert rst=0 mid-frame after 4 data bits, release, then send a full 0x1D frame -> all outputs 0 during reset; afterwards key_code=0x1D with exactly one strobe and no frame_err.
- Make: 0x1D frame at 12.5 kHz PS/2 clock (start 0, bits 1,0,1,1,1,0,0,0, parity 1, stop 1) -> key_code=0x1D one cycle before key_strobe; strobe lasts 1 clk; key_ext=0.
- Break and extended: frames F0,1D -> one strobe total, key_code=0x00. Frames E0,75 -> one strobe, key_code=0x75, key_ext=1. Frames E0,F0,75 -> key_code=0x00, key_ext=1.
- Bad parity / stop: 0x1D with parity 0 -> frame_err one pulse, no strobe, key_code retains prior value. Stop bit 0 gives the same response.
- Timeout: start plus 5 data bits, then hold ps2_clk high for TIMEOUT_CYC+10 cycles -> frame_err pulse at TIMEOUT_CYC; a following 0x6B frame decodes to key_code=0x6B.
- Glitch rejection: 3-clk low pulse on ps2_clk while IDLE, and FILTER_LEN-1 clk spikes mid-frame -> no state change, no strobe, no error; frame still decodes correctly.

Source files
------------

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: filters the raw pins, deframes 11-bit frames and
// folds E0/F0 prefixes into a key_code/key_ext pair with a one-clk strobe.
module ps2_scan_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_strobe,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } st_e;

  // index 0 carries ps2_clk, index 1 carries ps2_data
  logic [1:0]    s1_q, s2_q;
  logic [1:0]    flt_q, flt_d;
  logic [FW-1:0] fc_q [2];
  logic [FW-1:0] fc_d [2];
  logic          ckp_q;

  st_e           st_q, st_d;
  logic [2:0]    bc_q, bc_d;
  logic [8:0]    sh_q, sh_d;
  logic          pok_q, pok_d;
  logic [TW-1:0] to_q, to_d;
  logic          exf_q, exf_d;
  logic          brk_q, brk_d;
  logic [7:0]    code_q, code_d;
  logic          kext_q, kext_d;
  logic          acc_q, acc_d;
  logic          stb_q;
  logic          err_q, err_d;

  logic          fall;
  logic          din;
  logic          rx_ok;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      flt_d[i] = flt_q[i];
      fc_d[i]  = '0;
      if (s2_q[i] != flt_q[i]) begin
        if (fc_q[i] == FW'(FILTER_LEN - 1)) begin
          flt_d[i] = s2_q[i];
        end else begin
          fc_d[i] = fc_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall = ckp_q & ~flt_q[0];
  assign din  = flt_q[1];

  always_comb begin
    st_d   = st_q;
    bc_d   = bc_q;
    sh_d   = sh_q;
    pok_d  = pok_q;
    to_d   = '0;
    err_d  = 1'b0;
    rx_ok  = 1'b0;
    if (st_q != S_IDLE) begin
      to_d = to_q + 1'b1;
    end
    if (fall) begin
      to_d = '0;
      unique case (st_q)
        S_IDLE: begin
          if (!din) begin
            st_d = S_DATA;
            bc_d = '0;
          end
        end
        S_DATA: begin
          sh_d = {din, sh_q[8:1]};
          bc_d = bc_q + 1'b1;
          if (bc_q == 3'd7) begin
            st_d = S_PAR;
          end
        end
        S_PAR: begin
          sh_d  = {din, sh_q[8:1]};
          pok_d = ^{din, sh_q[8:1]};
          st_d  = S_STOP;
        end
        S_STOP: begin
          st_d = S_IDLE;
          if (din && pok_q) begin
            rx_ok = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end else if (st_q != S_IDLE &&
                 to_q == TW'(TIMEOUT_CYC - 1)) begin
      st_d  = S_IDLE;
      err_d = 1'b1;
      to_d  = '0;
    end
  end

  // prefixes only arm flags; any other byte resolves them
  always_comb begin
    exf_d  = exf_q;
    brk_d  = brk_q;
    code_d = code_q;
    kext_d = kext_q;
    acc_d  = 1'b0;
    if (rx_ok) begin
      if (sh_q[7:0] == 8'hE0) begin
        exf_d = 1'b1;
      end else if (sh_q[7:0] == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        code_d = brk_q ? 8'h00 : sh_q[7:0];
        kext_d = exf_q;
        exf_d  = 1'b0;
        brk_d  = 1'b0;
        acc_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      flt_q  <= 2'b11;
      fc_q   <= '{default: '0};
      ckp_q  <= 1'b1;
      st_q   <= S_IDLE;
      bc_q   <= '0;
      sh_q   <= '0;
      pok_q  <= 1'b0;
      to_q   <= '0;
      exf_q  <= 1'b0;
      brk_q  <= 1'b0;
      code_q <= 8'h00;
      kext_q <= 1'b0;
      acc_q  <= 1'b0;
      stb_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      s1_q   <= {ps2_data, ps2_clk};
      s2_q   <= s1_q;
      flt_q  <= flt_d;
      fc_q   <= fc_d;
      ckp_q  <= flt_q[0];
      st_q   <= st_d;
      bc_q   <= bc_d;
      sh_q   <= sh_d;
      pok_q  <= pok_d;
      to_q   <= to_d;
      exf_q  <= exf_d;
      brk_q  <= brk_d;
      code_q <= code_d;
      kext_q <= kext_d;
      acc_q  <= acc_d;
      stb_q  <= acc_q;
      err_q  <= err_d;
    end
  end

  assign key_code   = code_q;
  assign key_ext    = kext_q;
  assign key_strobe = stb_q;
  assign frame_err  = err_q;

endmodule
